cam_capture: RTL and testbench
==============================

Name: cam_capture

Overview:
- Captures pixel data from an OV7670-style camera parallel bus (VGA timing, RGB444 packed in 2 bytes/pixel) and presents 12-bit pixels with a write strobe and linear frame-buffer address.
- Sits between the camera pins (pclk domain) and a frame-buffer BRAM write port.
- Waits for the camera configuration to finish, discards the first frame, then captures every following frame.

Parameters:
- SKIP_FRAMES, 1, number of whole frames discarded after i_cam_done rises; range 0..3.
- ADDR_W, 19, pixel address width; covers 640*480 = 307200.

Ports:
- i_pclk  in  1  camera pixel clock (24 MHz); all logic on rising edge.
- i_rst  in  1  reset, asynchronous, active-high.
- i_vsync  in  1  high between frames; falling edge = frame start, rising edge = frame end.
- i_href  in  1  high while a row's bytes are valid.
- i_D  in  8  camera data byte.
- i_cam_done  in  1  camera register configuration complete; level.
- o_pix_addr  out  ADDR_W  pixel address (see Behaviour).
- o_pix_data  out  12  {first_byte[3:0], second_byte[7:0]}.
- o_wr  out  1  one-cycle write strobe per completed pixel.

Behaviour:
- Reset (asynchronous, active-high): o_wr=0, o_pix_data=0, o_pix_addr=0, byte phase=first, state=IDLE.
- Frame edge detection: i_vsync is registered one stage. fstart = prev 1 & now 0. fend = prev 0 & now 1.
- States:
  - IDLE: leave when i_cam_done=1; go to SKIP if SKIP_FRAMES>0, else ARM.
  - SKIP: count fstart events; after SKIP_FRAMES starts, go to ARM at the next fend.
  - ARM: on fstart, go to CAPTURE. o_pix_addr is cleared to 0 and the byte phase to first.
  - CAPTURE: on fend, go to ARM.
  - Any state: i_cam_done=0 returns to IDLE with o_wr=0.
- Outputs outside CAPTURE: o_wr=0; o_pix_addr and o_pix_data keep their values (0 until the first captured pixel). i_href and i_D are ignored.
- Byte handling in CAPTURE, on each rising edge with i_href=1 and i_vsync=0:
  - First phase: latch i_D[3:0]; go to second phase; o_wr=0.
  - Second phase, same edge (registered):
    - o_pix_data <= {latched[3:0], i_D};
    - o_wr <= 1;
    - o_pix_addr <= o_pix_addr+1;
    - go to first phase.
- Latency: o_wr, o_pix_data and o_pix_addr are valid immediately after the edge that samples the second byte. o_wr is high for exactly that one cycle.
- Address value: for pixel n (0-based, counted across rows within a frame), o_pix_addr reads n+1 while o_wr is high. Row 2 pixel 0 gives 641.
- i_href=0: byte phase is forced to first, o_wr=0, and o_pix_addr and o_pix_data hold. An odd trailing byte is dropped.
- Address saturates at 2^ADDR_W-1; it never wraps within a frame.
- Simultaneous fend and a data byte: fend wins and no write occurs.

Optional Feature:
- Macro CAM_CAPTURE_FRAME_DONE_EN.
- Defined: adds output o_frame_done (1 bit, reset 0). It pulses high for one cycle on the fend that ends a CAPTURE frame.
- Undefined: the port and its logic are absent; all other behaviour is identical.

Test Plan:
- Reset, then vsync 0->1 with i_cam_done=0 -> o_wr=0, o_pix_data=0, o_pix_addr=0.
- i_cam_done=1, one vsync high pulse, then a full 480x640x2-byte frame with i_href=0, then frame end -> all outputs remain 0 (skipped frame).
- New frame start; one row of bytes with i_href=0 -> outputs remain 0, no o_wr.
- i_href=1 for 1280 bytes -> o_wr high exactly after every 2nd byte. On byte 2k+1: o_pix_data={ROM[2k][3:0],ROM[2k+1]} and o_pix_addr=k+1. Example: bytes 0x0A,0x5C give 0xA5C at addr 1.
- i_href=0 for 5 cycles with changing i_D -> o_pix_addr (640) and o_pix_data hold; o_wr=0. Then a second row of 1280 bytes -> addr runs 641..1280.
- Assert i_rst mid-row -> all outputs 0 immediately and state IDLE. With i_cam_done still high, the skip sequence restarts.

Source files
------------

// File: rtl/cam_capture.sv
// cam_capture: OV7670-style parallel camera capture (RGB444, 2 bytes/pixel).
// Waits for camera configuration, discards SKIP_FRAMES whole frames, then
// writes every following frame as 12-bit pixels with a linear address.
// Optional: define CAM_CAPTURE_FRAME_DONE_EN to add the o_frame_done pulse.

module cam_capture #(
    parameter int SKIP_FRAMES = 1,
    parameter int ADDR_W      = 19
) (
    input  logic              i_pclk,
    input  logic              i_rst,
    input  logic              i_vsync,
    input  logic              i_href,
    input  logic [7:0]        i_D,
    input  logic              i_cam_done,
    output logic [ADDR_W-1:0] o_pix_addr,
    output logic [11:0]       o_pix_data,
    output logic              o_wr
`ifdef CAM_CAPTURE_FRAME_DONE_EN
    ,
    output logic              o_frame_done
`endif
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SKIP,
        ST_ARM,
        ST_CAPTURE
    } state_t;

    localparam logic [1:0]        SKIP_N   = 2'(SKIP_FRAMES);
    localparam logic [ADDR_W-1:0] ADDR_MAX = {ADDR_W{1'b1}};

    state_t            state_q, state_d;
    logic              vsync_q;
    logic [1:0]        skip_cnt_q, skip_cnt_d;
    logic              phase_q, phase_d;       // 0: expecting first byte, 1: second byte
    logic [3:0]        lo_nib_q, lo_nib_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [11:0]       data_q, data_d;
    logic              wr_q, wr_d;
`ifdef CAM_CAPTURE_FRAME_DONE_EN
    logic              frame_done_q, frame_done_d;
`endif

    logic fstart;
    logic fend;

    // Frame boundaries from the previous and current vsync samples.
    assign fstart = vsync_q & ~i_vsync;
    assign fend   = ~vsync_q & i_vsync;

    // Next-state and output computation for the capture FSM.
    always_comb begin
        // NOTE: every signal gets a default first so no path leaves it unassigned, which would infer a latch.
        state_d    = state_q;
        skip_cnt_d = skip_cnt_q;
        phase_d    = phase_q;
        lo_nib_d   = lo_nib_q;
        addr_d     = addr_q;
        data_d     = data_q;
        wr_d       = 1'b0;
`ifdef CAM_CAPTURE_FRAME_DONE_EN
        frame_done_d = 1'b0;
`endif

        if (!i_cam_done) begin
            // Configuration lost or not yet finished: park and drop any half pixel.
            state_d = ST_IDLE;
            phase_d = 1'b0;
        end else begin
            unique case (state_q)
                ST_IDLE: begin
                    skip_cnt_d = '0;
                    state_d    = (SKIP_FRAMES > 0) ? ST_SKIP : ST_ARM;
                end
                ST_SKIP: begin
                    // A frame counts as skipped only once its start has been seen.
                    if (fstart && skip_cnt_q != SKIP_N) begin
                        skip_cnt_d = skip_cnt_q + 2'd1;
                    end
                    if (fend && skip_cnt_q == SKIP_N) begin
                        state_d = ST_ARM;
                    end
                end
                ST_ARM: begin
                    if (fstart) begin
                        state_d = ST_CAPTURE;
                        addr_d  = '0;
                        phase_d = 1'b0;
                    end
                end
                ST_CAPTURE: begin
                    if (fend) begin
                        // Frame end takes priority over any byte on the same edge.
                        state_d = ST_ARM;
                        phase_d = 1'b0;
`ifdef CAM_CAPTURE_FRAME_DONE_EN
                        frame_done_d = 1'b1;
`endif
                    end else if (i_href && !i_vsync) begin
                        if (!phase_q) begin
                            lo_nib_d = i_D[3:0];
                            phase_d  = 1'b1;
                        end else begin
                            data_d  = {lo_nib_q, i_D};
                            wr_d    = 1'b1;
                            addr_d  = (addr_q == ADDR_MAX) ? addr_q : addr_q + 1'b1;
                            phase_d = 1'b0;
                        end
                    end else begin
                        // Row gap: an odd trailing byte is discarded.
                        phase_d = 1'b0;
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    // State and registered outputs, asynchronously reset.
    always_ff @(posedge i_pclk or posedge i_rst) begin
        // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
        if (i_rst) begin
            state_q    <= ST_IDLE;
            vsync_q    <= 1'b0;
            skip_cnt_q <= '0;
            phase_q    <= 1'b0;
            lo_nib_q   <= '0;
            addr_q     <= '0;
            data_q     <= '0;
            wr_q       <= 1'b0;
`ifdef CAM_CAPTURE_FRAME_DONE_EN
            frame_done_q <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            vsync_q    <= i_vsync;
            skip_cnt_q <= skip_cnt_d;
            phase_q    <= phase_d;
            lo_nib_q   <= lo_nib_d;
            addr_q     <= addr_d;
            data_q     <= data_d;
            wr_q       <= wr_d;
`ifdef CAM_CAPTURE_FRAME_DONE_EN
            frame_done_q <= frame_done_d;
`endif
        end
    end

    assign o_pix_addr = addr_q;
    assign o_pix_data = data_q;
    assign o_wr       = wr_q;
`ifdef CAM_CAPTURE_FRAME_DONE_EN
    assign o_frame_done = frame_done_q;
`endif

endmodule

// File: tb/tb_cam_capture.sv
// tb_cam_capture: randomized self-checking bench for cam_capture.
// A second instance with a 3-bit address runs on the same inputs so address
// saturation is observed alongside normal capture. Both instances are compared
// every cycle against a byte-queue model of the pixel stream.

module tb_cam_capture;

    localparam int ADDR_W = 19;
    localparam int SAT_W  = 3;

    logic              i_pclk = 1'b0;
    logic              i_rst;
    logic              i_vsync;
    logic              i_href;
    logic [7:0]        i_D;
    logic              i_cam_done;
    logic [ADDR_W-1:0] o_pix_addr;
    logic [11:0]       o_pix_data;
    logic              o_wr;
    logic [SAT_W-1:0]  sat_addr;
    logic [11:0]       sat_data;
    logic              sat_wr;
`ifdef CAM_CAPTURE_FRAME_DONE_EN
    logic              o_frame_done;
    logic              sat_fd;
`endif

    cam_capture #(.SKIP_FRAMES(1), .ADDR_W(ADDR_W)) u_dut (
        .i_pclk     (i_pclk),
        .i_rst      (i_rst),
        .i_vsync    (i_vsync),
        .i_href     (i_href),
        .i_D        (i_D),
        .i_cam_done (i_cam_done),
        .o_pix_addr (o_pix_addr),
        .o_pix_data (o_pix_data),
        .o_wr       (o_wr)
`ifdef CAM_CAPTURE_FRAME_DONE_EN
        ,
        .o_frame_done (o_frame_done)
`endif
    );

    cam_capture #(.SKIP_FRAMES(1), .ADDR_W(SAT_W)) u_sat (
        .i_pclk     (i_pclk),
        .i_rst      (i_rst),
        .i_vsync    (i_vsync),
        .i_href     (i_href),
        .i_D        (i_D),
        .i_cam_done (i_cam_done),
        .o_pix_addr (sat_addr),
        .o_pix_data (sat_data),
        .o_wr       (sat_wr)
`ifdef CAM_CAPTURE_FRAME_DONE_EN
        ,
        .o_frame_done (sat_fd)
`endif
    );

    always #5 i_pclk = ~i_pclk;

    // One clock of stimulus plus what the model expects of it.
    typedef struct packed {
        logic       vs;
        logic       href;
        logic       cap;    // bench knows the DUT is capturing on this edge
        logic       fs;     // this edge starts a captured frame (address restarts)
        logic       fd;     // frame-done pulse expected after this edge
        logic       done;
        logic [7:0] d;
    } step_t;

    step_t       plan[$];
    logic        cur_done = 1'b0;
    int          checks   = 0;
    int          errors   = 0;

    // Reference model: bytes of the current row pair up into pixels.
    logic [7:0]  q[$];
    int          m_pix  = 0;
    logic [11:0] m_data = '0;
    logic        m_wr   = 1'b0;
    logic        m_fd   = 1'b0;

    function automatic void add_steps(input int n, input logic vs, input logic href,
                                      input logic cap, input logic fs);
        for (int i = 0; i < n; i++) begin
            step_t s;
            s.vs   = vs;
            s.href = href;
            s.cap  = cap;
            s.fs   = fs;
            s.fd   = 1'b0;
            s.done = cur_done;
            s.d    = 8'($urandom);
            plan.push_back(s);
        end
    endfunction

    function automatic void model_reset();
        q.delete();
        m_pix  = 0;
        m_data = '0;
        m_wr   = 1'b0;
        m_fd   = 1'b0;
    endfunction

    function automatic logic [63:0] obs();
        logic [63:0] v;
        v = 64'({o_wr, o_pix_addr, o_pix_data, sat_wr, sat_addr, sat_data});
`ifdef CAM_CAPTURE_FRAME_DONE_EN
        v = {v[61:0], o_frame_done, sat_fd};
`endif
        return v;
    endfunction

    function automatic logic [63:0] expv();
        logic [63:0]      v;
        logic [SAT_W-1:0] exp_sat;
        exp_sat = (m_pix > 7) ? 3'd7 : SAT_W'(m_pix);
        v = 64'({m_wr, ADDR_W'(m_pix), m_data, m_wr, exp_sat, m_data});
`ifdef CAM_CAPTURE_FRAME_DONE_EN
        v = {v[61:0], m_fd, m_fd};
`endif
        return v;
    endfunction

    // Drive one step away from the active edge, then advance the model.
    task automatic step(input step_t s);
        @(negedge i_pclk);
        i_vsync    = s.vs;
        i_href     = s.href;
        i_D        = s.d;
        i_cam_done = s.done;
        @(posedge i_pclk);
        #1;
        if (s.fs) begin
            q.delete();
            m_pix = 0;
        end
        m_wr = 1'b0;
        m_fd = s.fd;
        if (!s.cap || s.vs || !s.href) begin
            q.delete();
        end else begin
            q.push_back(s.d);
            if (q.size() == 2) begin
                m_data = {q[0][3:0], q[1]};
                q.delete();
                m_pix++;
                m_wr = 1'b1;
            end
        end
    endtask

    task automatic test_reset();
        i_rst = 1'b1; i_vsync = 1'b0; i_href = 1'b0; i_D = '0; i_cam_done = 1'b0;
        model_reset();
        repeat (3) @(posedge i_pclk);
        #1;
        checks++;
        if (obs() !== 64'd0) begin
            errors++;
            $display("FAIL reset_state: outputs %h expected 0", obs());
        end
        @(negedge i_pclk);
        i_rst = 1'b0;
        plan.delete();
        cur_done = 1'b0;
        add_steps(4, 1'b0, 1'b1, 1'b0, 1'b0);
        add_steps(4, 1'b1, 1'b1, 1'b0, 1'b0);
        foreach (plan[k]) begin
            step(plan[k]);
            checks++;
            if (obs() !== expv()) begin
                errors++;
                $display("FAIL reset_no_config[%0d]: outputs %h expected %h", k, obs(), expv());
            end
        end
    endtask

    task automatic test_skip_frame();
        plan.delete();
        cur_done = 1'b1;
        add_steps(3, 1'b1, 1'b0, 1'b0, 1'b0);
        add_steps(1, 1'b0, 1'b0, 1'b0, 1'b0);
        for (int r = 0; r < 6; r++) begin
            add_steps(24, 1'b0, 1'b1, 1'b0, 1'b0);
            add_steps(3, 1'b0, 1'b0, 1'b0, 1'b0);
        end
        add_steps(3, 1'b1, 1'b1, 1'b0, 1'b0);
        foreach (plan[k]) begin
            step(plan[k]);
            checks++;
            if (obs() !== expv()) begin
                errors++;
                $display("FAIL skip_frame[%0d]: outputs %h expected %h", k, obs(), expv());
            end
        end
    endtask

    task automatic test_arm_quiet_row();
        plan.delete();
        add_steps(1, 1'b0, 1'b0, 1'b0, 1'b1);
        add_steps(1280, 1'b0, 1'b0, 1'b1, 1'b0);
        foreach (plan[k]) begin
            step(plan[k]);
            checks++;
            if (obs() !== expv()) begin
                errors++;
                $display("FAIL quiet_row[%0d]: outputs %h expected %h", k, obs(), expv());
            end
        end
    endtask

    task automatic test_row_one();
        plan.delete();
        add_steps(1280, 1'b0, 1'b1, 1'b1, 1'b0);
        plan[0].d = 8'h0A;
        plan[1].d = 8'h5C;
        foreach (plan[k]) begin
            step(plan[k]);
            checks++;
            if (obs() !== expv()) begin
                errors++;
                $display("FAIL row_one[%0d]: outputs %h expected %h", k, obs(), expv());
            end
            if (k == 1) begin
                checks++;
                if ({o_wr, o_pix_addr, o_pix_data} !== {1'b1, ADDR_W'(1), 12'hA5C}) begin
                    errors++;
                    $display("FAIL first_pixel: wr/addr/data %b/%0d/%h expected 1/1/a5c",
                             o_wr, o_pix_addr, o_pix_data);
                end
            end
        end
    endtask

    task automatic test_href_gap_and_row_two();
        plan.delete();
        add_steps(5, 1'b0, 1'b0, 1'b1, 1'b0);
        add_steps(1280, 1'b0, 1'b1, 1'b1, 1'b0);
        // Odd trailing byte, gap, then a fresh pair.
        add_steps(1, 1'b0, 1'b1, 1'b1, 1'b0);
        add_steps(1, 1'b0, 1'b0, 1'b1, 1'b0);
        add_steps(2, 1'b0, 1'b1, 1'b1, 1'b0);
        foreach (plan[k]) begin
            step(plan[k]);
            checks++;
            if (obs() !== expv()) begin
                errors++;
                $display("FAIL href_gap_row_two[%0d]: outputs %h expected %h", k, obs(), expv());
            end
        end
        checks++;
        if (o_pix_addr !== ADDR_W'(1281)) begin
            errors++;
            $display("FAIL odd_byte_addr: addr %0d expected 1281", o_pix_addr);
        end
    endtask

    task automatic test_frame_end();
        plan.delete();
        add_steps(1, 1'b0, 1'b1, 1'b1, 1'b0);
        add_steps(1, 1'b1, 1'b1, 1'b1, 1'b0);
        plan[plan.size() - 1].fd = 1'b1;
        add_steps(3, 1'b1, 1'b1, 1'b0, 1'b0);
        add_steps(1, 1'b0, 1'b0, 1'b0, 1'b1);
        foreach (plan[k]) begin
            step(plan[k]);
            checks++;
            if (obs() !== expv()) begin
                errors++;
                $display("FAIL frame_end[%0d]: outputs %h expected %h", k, obs(), expv());
            end
        end
    endtask

    task automatic test_saturation();
        plan.delete();
        add_steps(20, 1'b0, 1'b1, 1'b1, 1'b0);
        foreach (plan[k]) begin
            step(plan[k]);
            checks++;
            if (obs() !== expv()) begin
                errors++;
                $display("FAIL saturation[%0d]: outputs %h expected %h", k, obs(), expv());
            end
        end
    endtask

    task automatic test_cam_done_drop();
        plan.delete();
        cur_done = 1'b1;
        add_steps(1, 1'b0, 1'b1, 1'b1, 1'b0);
        cur_done = 1'b0;
        add_steps(3, 1'b0, 1'b1, 1'b0, 1'b0);
        cur_done = 1'b1;
        add_steps(6, 1'b0, 1'b1, 1'b0, 1'b0);
        add_steps(2, 1'b1, 1'b0, 1'b0, 1'b0);   // end of a frame never started: ignored
        add_steps(1, 1'b0, 1'b0, 1'b0, 1'b0);
        add_steps(10, 1'b0, 1'b1, 1'b0, 1'b0);
        add_steps(2, 1'b1, 1'b1, 1'b0, 1'b0);
        add_steps(1, 1'b0, 1'b0, 1'b0, 1'b1);
        add_steps(8, 1'b0, 1'b1, 1'b1, 1'b0);
        foreach (plan[k]) begin
            step(plan[k]);
            checks++;
            if (obs() !== expv()) begin
                errors++;
                $display("FAIL cam_done_drop[%0d]: outputs %h expected %h", k, obs(), expv());
            end
        end
    endtask

    task automatic test_reset_mid_row();
        plan.delete();
        add_steps(3, 1'b0, 1'b1, 1'b1, 1'b0);
        foreach (plan[k]) begin
            step(plan[k]);
            checks++;
            if (obs() !== expv()) begin
                errors++;
                $display("FAIL pre_reset_row[%0d]: outputs %h expected %h", k, obs(), expv());
            end
        end
        @(negedge i_pclk);
        i_rst = 1'b1;
        #1;
        model_reset();
        checks++;
        if (obs() !== 64'd0) begin
            errors++;
            $display("FAIL async_reset: outputs %h expected 0", obs());
        end
        repeat (2) @(negedge i_pclk);
        i_rst = 1'b0;
        plan.delete();
        add_steps(6, 1'b0, 1'b1, 1'b0, 1'b0);
        add_steps(1, 1'b1, 1'b0, 1'b0, 1'b0);
        add_steps(1, 1'b0, 1'b0, 1'b0, 1'b0);
        add_steps(12, 1'b0, 1'b1, 1'b0, 1'b0);
        add_steps(1, 1'b1, 1'b0, 1'b0, 1'b0);
        add_steps(1, 1'b0, 1'b0, 1'b0, 1'b1);
        add_steps(8, 1'b0, 1'b1, 1'b1, 1'b0);
        foreach (plan[k]) begin
            step(plan[k]);
            checks++;
            if (obs() !== expv()) begin
                errors++;
                $display("FAIL reset_restart[%0d]: outputs %h expected %h", k, obs(), expv());
            end
        end
    endtask

    initial begin
        test_reset();
        test_skip_frame();
        test_arm_quiet_row();
        test_row_one();
        test_href_gap_and_row_two();
        test_frame_end();
        test_saturation();
        test_cam_done_drop();
        test_reset_mid_row();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
